// File: rtl/sqrt_param.sv
// sqrt_param: iterative restoring integer square root, one root bit per clock.
// Define SQRT_ROUND_EN to round the root to nearest (saturating at all ones).
module sqrt_param #(
    parameter int WIDTH = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     valor,
    output logic [WIDTH/2-1:0]   sqrt,
    output logic [WIDTH/2:0]     resto,
    output logic                 endop,
    output logic                 busy
);
    localparam int N  = WIDTH / 2;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {IDLE, CALC} state_t;
    state_t state_q, state_d;

    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [N-1:0]     root_q, root_d;
    logic [N+1:0]     rem_q, rem_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [N-1:0]     sqrt_q, sqrt_d;
    logic [N:0]       resto_q, resto_d;
    logic             endop_q, endop_d;

    logic             accept, last, ge;
    logic [N+1:0]     rem_sh, trial;
    logic [N-1:0]     root_fin;

    assign accept = (state_q == IDLE) && start;
    assign last   = (state_q == CALC) && (cnt_q == '0);

    always_ff @(posedge clock) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start) state_d = CALC;
            CALC: if (cnt_q == '0) state_d = IDLE;
        endcase
    end

    always_comb begin
        busy  = (state_q == CALC);
        endop = endop_q;
        sqrt  = sqrt_q;
        resto = resto_q;
    end

    // One restoring step: bring down the next operand pair, try (root<<2)|1.
    always_comb begin
        rem_sh = (rem_q << 2) | {{N{1'b0}}, opnd_q[WIDTH-1 -: 2]};
        trial  = {root_q, 2'b01};
        ge     = (rem_sh >= trial);
        opnd_d = opnd_q;
        root_d = root_q;
        rem_d  = rem_q;
        cnt_d  = cnt_q;
        if (accept) begin
            opnd_d = valor;
            root_d = '0;
            rem_d  = '0;
            cnt_d  = CW'(N - 1);
        end else if (state_q == CALC) begin
            opnd_d = opnd_q << 2;
            rem_d  = ge ? (rem_sh - trial) : rem_sh;
            root_d = {root_q[N-2:0], ge};
            cnt_d  = cnt_q - CW'(1);
        end
    end

    always_comb begin
        root_fin = root_d;
`ifdef SQRT_ROUND_EN
        // rem > root means sqrt(valor) >= root + 0.5
        if ((rem_d > {2'b00, root_d}) && !(&root_d))
            root_fin = root_d + N'(1);
`endif
        sqrt_d  = sqrt_q;
        resto_d = resto_q;
        endop_d = 1'b0;
        if (last) begin
            sqrt_d  = root_fin;
            resto_d = rem_d[N:0];
            endop_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            opnd_q  <= '0;
            root_q  <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            sqrt_q  <= '0;
            resto_q <= '0;
            endop_q <= 1'b0;
        end else begin
            opnd_q  <= opnd_d;
            root_q  <= root_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            sqrt_q  <= sqrt_d;
            resto_q <= resto_d;
            endop_q <= endop_d;
        end
    end
endmodule

// File: doc/sqrt_param.md
# sqrt_param

Parametrised iterative integer square root, successor to the fixed 16-bit `sqrt` unit. It computes floor(sqrt(valor)) and the remainder for any even operand width, one result bit per clock, using a restoring digit-pair algorithm. It adds a start/busy handshake, a remainder output and optional round-to-nearest. It sits in the datapath as a multi-cycle arithmetic slave that is started by a controller and signals completion with a one-cycle `endop` pulse.

## Interface
- `WIDTH`, default 16: operand width in bits; must be even and ≥ 4. N = WIDTH/2 is the root width and the iteration count.
- `clock` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-low reset, sampled on the rising edge of `clock`.
- `start` input 1: request a computation; sampled only in IDLE.
- `valor` input WIDTH: unsigned radicand; captured on the accepting edge.
- `sqrt` output N: registered root (truncated, or rounded when enabled).
- `resto` output N+1: registered remainder, valor − floor_root²; always the truncated remainder.
- `endop` output 1: one-cycle pulse when `sqrt`/`resto` update.
- `busy` output 1: high while a computation is in progress.

## Operation
- States: IDLE, CALC.
- IDLE with `start`=1: capture `valor` into the operand shift register, clear the working root and remainder, load the iteration counter with N−1, go to CALC, and set `busy`=1.
- IDLE with `start`=0: hold.
- CALC, one iteration per edge, MSB pair first:
  - rem ← (rem << 2) | next two operand bits.
  - trial ← (root << 2) | 1.
  - If rem ≥ trial, then rem ← rem − trial and root ← (root << 1) | 1; otherwise root ← root << 1.
- Working remainder register is N+2 bits wide. The final remainder never exceeds 2·root, so it fits in N+1 bits.
- Final iteration (counter = 0):
  - Load `sqrt` and `resto`.
  - Pulse `endop`=1 for one cycle.
  - Clear `busy` and return to IDLE.
- `start` during CALC is ignored. `valor` changes after capture have no effect.
- `sqrt` and `resto` hold their last result until the next completion. `endop` is never asserted without a preceding accepted `start`.
- Reset (`reset`=0 at an edge), including mid-CALC: abort, go to IDLE, and set `sqrt`=0, `resto`=0, `endop`=0, `busy`=0. Reset has priority over `start`.

## Timing
- Reset values: `sqrt`=0, `resto`=0, `endop`=0, `busy`=0, state IDLE.
- Accepting edge E, where `start`=1 in IDLE: `busy`=1 from E.
- Iterations run on edges E+1 … E+N. At edge E+N the outputs are valid, `endop`=1 and `busy`=0; `endop` drops at E+N+1.
- Latency is N cycles from the accepting edge to `endop`. Minimum issue interval is N+1 cycles, since a `start` held high is accepted again at E+N+1.
- WIDTH=16 gives 8 cycles of latency and a 9-cycle interval.

## Configuration
- `SQRT_ROUND_EN` defined:
  - If the final rem > root, `sqrt` = root+1, because sqrt(valor) ≥ root+0.5 ⇔ rem ≥ root+1.
  - The result saturates at 2^N−1, so it never wraps.
  - `resto` stays the truncated remainder.
  - No extra latency; the rounding compare and increment happen in the final-iteration cycle.
- `SQRT_ROUND_EN` undefined: `sqrt` is always floor(sqrt(valor)). The compare/increment logic is absent.

## Test plan
- WIDTH=16, reset low for 3 cycles, then `valor`=4 with a one-cycle `start` → `busy` high for 8 cycles, then `endop` pulse with `sqrt`=2, `resto`=0. Outputs are 0 during reset.
- `valor`=65535 → `sqrt`=255, `resto`=510. With `SQRT_ROUND_EN`, `sqrt`=255 (saturated). `valor`=0 → `sqrt`=0, `resto`=0.
- `valor`=7 → without the macro `sqrt`=2, `resto`=3; with it `sqrt`=3, `resto`=3. `valor`=6 → `sqrt`=2 in both builds.
- `start` held high for 20 cycles, with `valor` changed mid-computation → results 9 cycles apart, each matching the `valor` present at its own accepting edge.
- `reset` low at the 4th CALC cycle → next edge shows `busy`=0, `sqrt`=0, `resto`=0, and no `endop` follows. A new `start` then completes normally.
- WIDTH=8 and WIDTH=32, random operands → `sqrt`² ≤ valor < (`sqrt`+1)², `resto` = valor − `sqrt`², and latency = WIDTH/2.
